// File: rtl/jtframe_pulse_sched.sv
// jtframe_pulse_sched
//   Shares one stretched-pulse output (LED, rumble, buzzer) between N
//   asynchronous event sources. Each source is synchronised and rising-edge
//   detected into a pending latch. Pending events are served round-robin as
//   an on-pulse of len cen ticks followed by a quiet gap of gap cen ticks.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   cen        timing tick; length/gap counters only advance when high
//   req        N event inputs, any clock domain; each rising edge is an event
//   len        on-time in cen ticks, sampled on grant (0 behaves as 1)
//   gap        off-time in cen ticks, sampled at end of ON (0 = no gap)
//   pulse_out  shared registered output, high while serving a slot
//   active_id  channel currently or most recently served
//   pending    latched events not yet served
//   busy       high during ON or GAP
//
// States
//   ST_IDLE | waiting for a pending event; grants in one clk when any pending
//   ST_ON   | pulse_out high, counting len cen ticks
//   ST_GAP  | pulse_out low, counting gap cen ticks before the next grant
module jtframe_pulse_sched #(
  parameter int N   = 4,
  parameter int W   = 14,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic [N-1:0]   req,
  input  logic [W-1:0]   len,
  input  logic [W-1:0]   gap,
  output logic           pulse_out,
  output logic [IDW-1:0] active_id,
  output logic [N-1:0]   pending,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   cnt;
  logic [IDW-1:0] last;

  logic [N-1:0]   sync1;
  logic [N-1:0]   sync2;
  logic [N-1:0]   prev;
  logic [N-1:0]   rise;

  logic [IDW-1:0] pick;
  logic           grant;
  logic [N-1:0]   grant_mask;
  int             best_dist;
  int             scan_dist;

  // All three flops reset low, so a req held high across reset release
  // still produces exactly one event.
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= req;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  // Round-robin pick: the pending channel with the smallest distance
  // upward from last+1 (mod N) wins. Distance is computed per constant
  // index so no variable bit-select is needed.
  always_comb begin
    pick      = '0;
    best_dist = N;
    scan_dist = 0;
    for (int i = 0; i < N; i++) begin
      scan_dist = (i + 2 * N - 1 - int'(last)) % N;
      if (pending[i] && (scan_dist < best_dist)) begin
        best_dist = scan_dist;
        pick      = IDW'(i);
      end
    end
  end

  assign grant      = (state == ST_IDLE) && (pending != '0);
  assign grant_mask = grant ? (N'(1) << pick) : '0;

  // A new edge wins over the grant-clear on the same channel.
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | rise;
    end
  end

  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last      <= IDW'(N - 1);
      active_id <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state     <= ST_ON;
            active_id <= pick;
            last      <= pick;
            cnt       <= (len == '0) ? W'(1) : len;
            pulse_out <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_ON: begin
          if (cen) begin
            // <= rather than == keeps cnt from ever wrapping below zero
            if (cnt <= W'(1)) begin
              pulse_out <= 1'b0;
              if (gap != '0) begin
                cnt   <= gap;
                state <= ST_GAP;
              end else begin
                cnt   <= '0;
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt - W'(1);
            end
          end
        end
        ST_GAP: begin
          if (cen) begin
            if (cnt <= W'(1)) begin
              cnt   <= '0;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - W'(1);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          pulse_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_pulse_sched.sv
// tb_jtframe_pulse_sched
//   Directed and randomized checks for jtframe_pulse_sched. Expected serve
//   orders come from a round-robin model over request masks; expected pulse
//   and gap widths come from len/gap directly.
module tb_jtframe_pulse_sched;
  localparam int N   = 4;
  localparam int W   = 14;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           cen;
  logic [N-1:0]   req;
  logic [W-1:0]   len;
  logic [W-1:0]   gap;
  logic           pulse_out;
  logic [IDW-1:0] active_id;
  logic [N-1:0]   pending;
  logic           busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int cen_div = 1;
  int m_last;
  int exp_q[$];
  int hi;
  int lo;
  int want_hi;
  logic [N-1:0] mask;

  jtframe_pulse_sched #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .req       (req),
    .len       (len),
    .gap       (gap),
    .pulse_out (pulse_out),
    .active_id (active_id),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, want);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    cen = (cen_div <= 1) ? 1'b1 : ((cyc % cen_div) == 0);
  endtask

  task automatic pulse_req(input logic [N-1:0] m);
    req = req | m;
    step();
    req = req & ~m;
  endtask

  task automatic wait_rise(input string tag);
    int n;
    n = 0;
    while (!pulse_out && n < 60) begin
      step();
      n++;
    end
    check(tag, 32'(pulse_out), 32'd1);
  endtask

  // Starting on a high sample: count high cycles, then busy-low cycles.
  task automatic meas_slot(output int h, output int l);
    h = 0;
    l = 0;
    while (pulse_out && h < 1000) begin
      h++;
      step();
    end
    while (busy && !pulse_out && l < 1000) begin
      l++;
      step();
    end
  endtask

  task automatic quiet(input string tag, input int n);
    int highs;
    highs = 0;
    repeat (n) begin
      step();
      if (pulse_out) highs++;
    end
    check(tag, 32'(highs), 32'd0);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    cen = 1'b1;
    len = W'(5);
    gap = W'(3);
    repeat (3) step();
    check("rst_pulse", 32'(pulse_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_id", 32'(active_id), 32'd0);
    rst = 1'b0;
    repeat (2) step();

    // Single event on channel 2
    req = 4'b0100;
    step();
    req = '0;
    step();
    check("single_pend_early", 32'(pending), 32'd0);
    step();
    check("single_pend_set", 32'(pending), 32'b0100);
    check("single_not_yet", 32'(pulse_out), 32'd0);
    step();
    check("single_pulse", 32'(pulse_out), 32'd1);
    check("single_id", 32'(active_id), 32'd2);
    check("single_pend_clr", 32'(pending), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    meas_slot(hi, lo);
    check("single_hi", 32'(hi), 32'd5);
    check("single_gap", 32'(lo), 32'd3);
    check("single_busy_len", 32'(hi + lo), 32'd8);
    check("single_idle", 32'(busy), 32'd0);
    check("single_pend_end", 32'(pending), 32'd0);

    // Round robin from reset: all four at once
    do_reset();
    len = W'(2);
    gap = W'(1);
    pulse_req(4'b1111);
    wait_rise("rr_rise");
    for (int k = 0; k < 4; k++) begin
      check("rr_id", 32'(active_id), 32'(k));
      meas_slot(hi, lo);
      check("rr_hi", 32'(hi), 32'd2);
      check("rr_gap", 32'(lo), 32'd1);
      check("rr_idle", 32'(busy), 32'd0);
      if (k < 3) begin
        step();
        check("rr_idle_1clk", 32'(pulse_out), 32'd1);
      end
    end
    check("rr_pend_end", 32'(pending), 32'd0);

    // Fairness after serving channel 1
    pulse_req(4'b0010);
    wait_rise("fair_rise1");
    check("fair_id1", 32'(active_id), 32'd1);
    meas_slot(hi, lo);
    pulse_req(4'b1001);
    wait_rise("fair_rise3");
    check("fair_id3", 32'(active_id), 32'd3);
    meas_slot(hi, lo);
    wait_rise("fair_rise0");
    check("fair_id0", 32'(active_id), 32'd0);
    meas_slot(hi, lo);

    // Coalescing on channel 1 and re-arm of channel 0 during its own slot
    len = W'(10);
    gap = W'(1);
    pulse_req(4'b0001);
    wait_rise("coal_rise");
    check("coal_id0", 32'(active_id), 32'd0);
    pulse_req(4'b0010);
    step();
    pulse_req(4'b0010);
    step();
    pulse_req(4'b0011);
    meas_slot(hi, lo);
    check("coal_hi_rest", 32'(hi), 32'd5);
    check("coal_pending", 32'(pending), 32'b0011);
    step();
    check("coal_rise1", 32'(pulse_out), 32'd1);
    check("coal_id1", 32'(active_id), 32'd1);
    meas_slot(hi, lo);
    step();
    check("rearm_rise0", 32'(pulse_out), 32'd1);
    check("rearm_id0", 32'(active_id), 32'd0);
    meas_slot(hi, lo);
    quiet("coal_no_extra", 20);
    check("coal_pend_end", 32'(pending), 32'd0);

    // cen every 4th clock
    cen_div = 4;
    len = W'(3);
    gap = W'(0);
    pulse_req(4'b0100);
    wait_rise("cen_rise");
    meas_slot(hi, lo);
    check("cen_hi_range", 32'((hi >= 9) && (hi <= 12)), 32'd1);
    check("cen_gap0", 32'(lo), 32'd0);
    cen_div = 1;
    step();

    // len=0 and gap=0
    len = W'(0);
    gap = W'(0);
    pulse_req(4'b1001);
    wait_rise("zero_rise");
    check("zero_id3", 32'(active_id), 32'd3);
    meas_slot(hi, lo);
    check("zero_hi", 32'(hi), 32'd1);
    check("zero_gap", 32'(lo), 32'd0);
    step();
    check("zero_low_1clk", 32'(pulse_out), 32'd1);
    check("zero_id0", 32'(active_id), 32'd0);
    meas_slot(hi, lo);
    check("zero_hi2", 32'(hi), 32'd1);

    // Reset mid-slot with two channels pending
    len = W'(8);
    gap = W'(2);
    pulse_req(4'b0001);
    wait_rise("mid_rise");
    pulse_req(4'b0110);
    step();
    step();
    check("mid_pend_pre", 32'(pending), 32'b0110);
    check("mid_on_pre", 32'(pulse_out), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_pulse", 32'(pulse_out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pend", 32'(pending), 32'd0);
    check("mid_rst_id", 32'(active_id), 32'd0);
    req = 4'b1000;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    step();
    check("held_not_yet", 32'(pulse_out), 32'd0);
    check("held_pend", 32'(pending), 32'b1000);
    step();
    check("held_pulse", 32'(pulse_out), 32'd1);
    check("held_id", 32'(active_id), 32'd3);
    meas_slot(hi, lo);
    check("held_hi", 32'(hi), 32'd8);
    check("held_gap", 32'(lo), 32'd2);
    quiet("held_once", 20);
    req = '0;
    step();

    // Randomized rounds against the round-robin model
    do_reset();
    m_last = N - 1;
    for (int r = 0; r < 12; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      len  = W'($urandom_range(0, 5));
      gap  = W'($urandom_range(0, 4));
      want_hi = (len == '0) ? 1 : int'(len);
      exp_q.delete();
      for (int k = 1; k <= N; k++) begin
        int ch;
        ch = (m_last + k) % N;
        if (mask[2'(ch)]) exp_q.push_back(ch);
      end
      pulse_req(mask);
      wait_rise("rnd_rise");
      for (int j = 0; j < exp_q.size(); j++) begin
        check("rnd_id", 32'(active_id), 32'(exp_q[j]));
        meas_slot(hi, lo);
        check("rnd_hi", 32'(hi), 32'(want_hi));
        check("rnd_gap", 32'(lo), 32'(gap));
        if (j < exp_q.size() - 1) begin
          step();
          check("rnd_next", 32'(pulse_out), 32'd1);
        end
      end
      m_last = exp_q[exp_q.size() - 1];
      check("rnd_pend_end", 32'(pending), 32'd0);
      check("rnd_busy_end", 32'(busy), 32'd0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jtframe_pulse_sched.md
# jtframe_pulse_sched

Round-robin scheduler that shares one stretched-pulse output (status LED, rumble or buzzer line) between N asynchronous event sources. Each event source is synchronised and edge-detected, then latched as pending. Pending events are served one at a time as an on-pulse of programmable length followed by a programmable quiet gap, so back-to-back events stay individually visible. It sits between core event strobes and the board-level indicator output.

## Interface

Parameters:
- N, 4, number of requesters (2..16)
- W, 14, width of the length/gap counters
- IDW, 2, width of active_id; must satisfy 2**IDW >= N

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  timing tick; all length/gap counting advances only on cycles with cen=1
- req  in  N  event inputs, any clock domain, level; each rising edge is one event
- len  in  W  on-time in cen ticks; sampled on grant; 0 is treated as 1
- gap  in  W  off-time in cen ticks; sampled at end of ON; 0 means no gap
- pulse_out  out  1  shared output, registered
- active_id  out  IDW  index of the channel currently or last served
- pending  out  N  latched, not-yet-served events
- busy  out  1  high in ON or GAP

## Operation

- Per channel, a 2-flop synchroniser feeds a previous-value flop. An edge is detected when the synchronised value is 1 and the previous value is 0. All three flops reset to 0, so a req held high through reset release counts as one event.
- A detected edge sets pending[i]. Repeated edges on an already pending channel coalesce into one event. If a set and a grant-clear hit the same channel in the same cycle, set wins and the channel stays pending.
- FSM states: IDLE, ON, GAP.
- IDLE:
  - If pending != 0, pick the first set bit scanning upward from last+1 mod N, where last is the previously granted index.
  - In the same cycle: clear that pending bit, set active_id and last, load cnt = max(len,1), and go to ON.
  - If pending == 0, stay in IDLE.
- ON: pulse_out=1. On each cen, cnt decrements. A cen with cnt==1 ends ON:
  - if gap != 0, load cnt=gap and go to GAP;
  - else go to IDLE.
- GAP: pulse_out=0. On each cen, cnt decrements. A cen with cnt==1 goes to IDLE.
- An edge arriving on the channel currently being served sets its pending bit again, and that channel is served in a later slot.
- A slot in progress is never pre-empted.
- len and gap changes mid-slot have no effect until the next load.
- Round-robin guarantee: a pending channel waits at most N-1 slots.

## Timing

- Reset values:
  - pulse_out=0, busy=0, pending=0, active_id=0, state IDLE, cnt=0.
  - last=N-1, so channel 0 has first priority after reset.
- req rise sampled at clk edge t:
  - synchronised value is 1 after edge t+1;
  - pending[i]=1 after edge t+2;
  - grant at edge t+3: state ON, pulse_out=1, busy=1, pending[i]=0.
  - Fixed latency from IDLE is 4 clk.
- pulse_out is a direct registered decode of state==ON, with no combinational path from req.
- ON lasts exactly max(len,1) cen pulses, counted from the first cen after the grant edge. GAP lasts exactly gap cen pulses.
- From IDLE to the next grant is 1 clk whenever pending != 0, so there is a 1-clk minimum low time between consecutive pulses even with gap=0.
- With cen tied to 1, ON is max(len,1) clk and GAP is gap clk.
- An rst assertion mid-slot immediately forces all reset values. Events in flight are lost.
- cnt never wraps: it is only decremented while >=1.

## Test plan

- Single event: N=4, cen=1, len=5, gap=3, pulse req[2] for one clk:
  - pending[2] is set 3 clk after the rise;
  - pulse_out is high for exactly 5 clk starting 4 clk after the rise;
  - active_id=2;
  - busy stays high for 8 clk;
  - then IDLE with pending=0.
- Round robin: all four req rise in the same cycle with len=2, gap=1, cen=1:
  - pulses are served in order 0,1,2,3;
  - each pulse is 2 clk high, followed by 1 clk gap and 1 clk IDLE;
  - active_id steps 0→1→2→3.
- Fairness after grant: serve channel 1, then raise req[0] and req[3] together:
  - order is 3 then 0 (scan starts at 2).
- Coalescing and re-arm:
  - three edges on req[1] during one ON slot of channel 0 produce exactly one further pulse on channel 1;
  - an edge on req[0] during its own ON slot produces a second channel-0 pulse afterwards.
- Tick gating and zero values:
  - cen=1 every 4th clk with len=3: pulse_out is high for 3 cen pulses (9-12 clk, depending on cen phase relative to grant);
  - len=0 gives a 1-cen pulse;
  - gap=0 gives exactly 1 clk low between pulses.
- Reset mid-slot:
  - assert rst during ON with two channels pending: all outputs go to 0 asynchronously;
  - after release, no pulse occurs unless a req is high (a held-high req yields exactly one pulse, 4 clk later).
